// File: rtl/vmx_pkg.sv
// Shared definitions for the vmx stream arbiter: FSM state encoding and default widths.
package vmx_pkg;

    localparam int C_DEFAULT_TDATA_WIDTH = 32;

    // State encoding doubles as the one-hot owner pattern driven on GRANT.
    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_GRANT0 = 2'b01,
        S_GRANT1 = 2'b10
    } state_t;

    function automatic logic [1:0] grant_of(input state_t state);
        logic [1:0] grant;
        grant = 2'b00;
        case (state)
            S_GRANT0: grant = 2'b01;
            S_GRANT1: grant = 2'b10;
            default:  grant = 2'b00;
        endcase
        return grant;
    endfunction

endpackage

// File: rtl/vmx_strb_mask.sv
// Zeroes every data byte whose strobe bit is clear.
module vmx_strb_mask
    import vmx_pkg::*;
#(
    parameter int DATA_WIDTH = C_DEFAULT_TDATA_WIDTH
)(
    input  logic [DATA_WIDTH-1:0]   i_tdata,
    input  logic [DATA_WIDTH/8-1:0] i_tstrb,
    output logic [DATA_WIDTH-1:0]   o_tdata
);

    for (genvar i = 0; i < DATA_WIDTH/8; i++) begin : g_byte
        assign o_tdata[8*i +: 8] = i_tstrb[i] ? i_tdata[8*i +: 8] : 8'h00;
    end

endmodule

// File: rtl/vmx_stream_arbiter.sv
// Two-requester AXI-Stream packet arbiter feeding a shared FIFO, with
// round-robin tie breaking and per-requester completed-packet counters.
module vmx_stream_arbiter
    import vmx_pkg::*;
#(
    parameter int C_S_AXIS_TDATA_WIDTH = C_DEFAULT_TDATA_WIDTH,
    parameter int C_PKT_CNT_WIDTH      = 16
)(
    input  logic                              S_AXIS_ACLK,
    input  logic                              S_AXIS_ARESETN,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S0_AXIS_TDATA,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S0_AXIS_TSTRB,
    input  logic                              S0_AXIS_TLAST,
    input  logic                              S0_AXIS_TVALID,
    output logic                              S0_AXIS_TREADY,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S1_AXIS_TDATA,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S1_AXIS_TSTRB,
    input  logic                              S1_AXIS_TLAST,
    input  logic                              S1_AXIS_TVALID,
    output logic                              S1_AXIS_TREADY,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]   FIFO_DATA,
    output logic                              FIFO_LAST,
    output logic                              FIFO_WREN,
    input  logic                              FIFO_FULL,
    output logic [1:0]                        GRANT,
    output logic [C_PKT_CNT_WIDTH-1:0]        PKT_CNT0,
    output logic [C_PKT_CNT_WIDTH-1:0]        PKT_CNT1
);

    localparam int C_STRB_WIDTH = C_S_AXIS_TDATA_WIDTH / 8;

    state_t                       r_state;
    state_t                       w_next_state;
    logic                         r_last_served;
    logic [1:0]                   r_grant;
    logic [C_PKT_CNT_WIDTH-1:0]   r_pkt_cnt0;
    logic [C_PKT_CNT_WIDTH-1:0]   r_pkt_cnt1;

    logic [C_S_AXIS_TDATA_WIDTH-1:0] w_owner_data;
    logic [C_STRB_WIDTH-1:0]         w_owner_strb;
    logic                            w_owner_last;
    logic                            w_owner_valid;
    logic                            w_owner_ready;
    logic                            w_handshake;
    logic                            w_pkt_done;

    // Owner mux: with no owner every field is zero, so the FIFO side idles at 0.
    always_comb begin
        w_owner_data  = '0;
        w_owner_strb  = '0;
        w_owner_last  = 1'b0;
        w_owner_valid = 1'b0;
        case (r_state)
            S_GRANT0: begin
                w_owner_data  = S0_AXIS_TDATA;
                w_owner_strb  = S0_AXIS_TSTRB;
                w_owner_last  = S0_AXIS_TLAST;
                w_owner_valid = S0_AXIS_TVALID;
            end
            S_GRANT1: begin
                w_owner_data  = S1_AXIS_TDATA;
                w_owner_strb  = S1_AXIS_TSTRB;
                w_owner_last  = S1_AXIS_TLAST;
                w_owner_valid = S1_AXIS_TVALID;
            end
            default: ;
        endcase
    end

    assign S0_AXIS_TREADY = (r_state == S_GRANT0) && !FIFO_FULL;
    assign S1_AXIS_TREADY = (r_state == S_GRANT1) && !FIFO_FULL;
    assign w_owner_ready  = S0_AXIS_TREADY || S1_AXIS_TREADY;
    assign w_handshake    = w_owner_valid && w_owner_ready;
    assign w_pkt_done     = w_handshake && w_owner_last;

    vmx_strb_mask #(
        .DATA_WIDTH (C_S_AXIS_TDATA_WIDTH)
    ) u_strb_mask (
        .i_tdata (w_owner_data),
        .i_tstrb (w_owner_strb),
        .o_tdata (FIFO_DATA)
    );

    assign FIFO_LAST = w_owner_last;
    assign FIFO_WREN = w_handshake;
    assign GRANT     = r_grant;
    assign PKT_CNT0  = r_pkt_cnt0;
    assign PKT_CNT1  = r_pkt_cnt1;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (S0_AXIS_TVALID && S1_AXIS_TVALID)
                    w_next_state = r_last_served ? S_GRANT0 : S_GRANT1;
                else if (S0_AXIS_TVALID)
                    w_next_state = S_GRANT0;
                else if (S1_AXIS_TVALID)
                    w_next_state = S_GRANT1;
            end
            S_GRANT0, S_GRANT1: begin
                if (w_pkt_done)
                    w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // GRANT is decoded from the next state so it tracks r_state cycle for cycle.
    always_ff @(posedge S_AXIS_ACLK) begin
        if (!S_AXIS_ARESETN) begin
            r_state       <= S_IDLE;
            r_last_served <= 1'b1;
            r_grant       <= 2'b00;
            r_pkt_cnt0    <= '0;
            r_pkt_cnt1    <= '0;
        end else begin
            r_state <= w_next_state;
            r_grant <= grant_of(w_next_state);
            if (w_pkt_done)
                r_last_served <= (r_state == S_GRANT1);
            if (w_pkt_done && (r_state == S_GRANT0))
                r_pkt_cnt0 <= r_pkt_cnt0 + C_PKT_CNT_WIDTH'(1);
            if (w_pkt_done && (r_state == S_GRANT1))
                r_pkt_cnt1 <= r_pkt_cnt1 + C_PKT_CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_vmx_stream_arbiter.sv
// Directed self-checking bench for vmx_stream_arbiter; counters are 2 bits
// wide so wrap-around and the reset-after-three-packets case are reachable.
module tb_vmx_stream_arbiter;

    logic        clock;
    logic        aresetn;
    logic [31:0] s0Data, s1Data;
    logic [3:0]  s0Strb, s1Strb;
    logic        s0Last, s1Last, s0Valid, s1Valid;
    logic        s0Ready, s1Ready;
    logic [31:0] fifoData;
    logic        fifoLast, fifoWren, fifoFull;
    logic [1:0]  grant;
    logic [1:0]  pktCnt0, pktCnt1;

    int checkCount = 0;
    int errorCount = 0;

    vmx_stream_arbiter #(
        .C_S_AXIS_TDATA_WIDTH (32),
        .C_PKT_CNT_WIDTH      (2)
    ) dut (
        .S_AXIS_ACLK    (clock),
        .S_AXIS_ARESETN (aresetn),
        .S0_AXIS_TDATA  (s0Data),
        .S0_AXIS_TSTRB  (s0Strb),
        .S0_AXIS_TLAST  (s0Last),
        .S0_AXIS_TVALID (s0Valid),
        .S0_AXIS_TREADY (s0Ready),
        .S1_AXIS_TDATA  (s1Data),
        .S1_AXIS_TSTRB  (s1Strb),
        .S1_AXIS_TLAST  (s1Last),
        .S1_AXIS_TVALID (s1Valid),
        .S1_AXIS_TREADY (s1Ready),
        .FIFO_DATA      (fifoData),
        .FIFO_LAST      (fifoLast),
        .FIFO_WREN      (fifoWren),
        .FIFO_FULL      (fifoFull),
        .GRANT          (grant),
        .PKT_CNT0       (pktCnt0),
        .PKT_CNT1       (pktCnt1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic stepClock();
        @(posedge clock);
        #1;
    endtask

    // Drives both requesters and FIFO_FULL, then lets combinational outputs settle.
    task automatic applyStimulus(
        input logic v0, input logic [31:0] d0, input logic [3:0] st0, input logic l0,
        input logic v1, input logic [31:0] d1, input logic [3:0] st1, input logic l1,
        input logic full);
        s0Valid = v0; s0Data = d0; s0Strb = st0; s0Last = l0;
        s1Valid = v1; s1Data = d1; s1Strb = st1; s1Last = l1;
        fifoFull = full;
        #1;
    endtask

    logic [1:0]  expGrantSeq [12];
    int          s0Pkt, s0Beat, s1Pkt, s1Beat, wrenCount;
    logic [31:0] s0Word, s1Word;

    initial begin
        expGrantSeq = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10,
                        2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10};

        // Reset state
        aresetn = 1'b0;
        applyStimulus(0, 32'h0, 4'h0, 0, 0, 32'h0, 4'h0, 0, 0);
        stepClock();
        stepClock();
        checkOutput("rstGrant", 32'(grant), 32'h0);
        checkOutput("rstCnt0", 32'(pktCnt0), 32'h0);
        checkOutput("rstCnt1", 32'(pktCnt1), 32'h0);
        checkOutput("rstWren", 32'(fifoWren), 32'h0);
        checkOutput("rstData", fifoData, 32'h0);
        aresetn = 1'b1;

        // Single requester, four-beat packet
        applyStimulus(1, 32'h11111111, 4'hF, 0, 0, 32'h0, 4'h0, 0, 0);
        checkOutput("aIdleWren", 32'(fifoWren), 32'h0);
        stepClock();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 32'h11111111 * (i + 1), 4'hF, (i == 3), 0, 32'h0, 4'h0, 0, 0);
            checkOutput("aGrant", 32'(grant), 32'h1);
            checkOutput("aWren", 32'(fifoWren), 32'h1);
            checkOutput("aData", fifoData, 32'h11111111 * (i + 1));
            checkOutput("aLast", 32'(fifoLast), 32'(i == 3));
            stepClock();
        end
        applyStimulus(0, 32'h0, 4'h0, 0, 0, 32'h0, 4'h0, 0, 0);
        checkOutput("aDoneGrant", 32'(grant), 32'h0);
        checkOutput("aDoneWren", 32'(fifoWren), 32'h0);
        checkOutput("aCnt0", 32'(pktCnt0), 32'h1);

        // Round robin from reset: both requesters, two 2-beat packets each
        aresetn = 1'b0;
        stepClock();
        aresetn = 1'b1;
        s0Pkt = 0; s0Beat = 0; s1Pkt = 0; s1Beat = 0;
        for (int c = 0; c < 12; c++) begin
            s0Word = 32'hA0000000 + 32'(s0Pkt * 16 + s0Beat);
            s1Word = 32'hB0000000 + 32'(s1Pkt * 16 + s1Beat);
            applyStimulus(s0Pkt < 2, s0Word, 4'hF, s0Beat == 1,
                          s1Pkt < 2, s1Word, 4'hF, s1Beat == 1, 0);
            checkOutput("bGrant", 32'(grant), 32'(expGrantSeq[c]));
            if (expGrantSeq[c] == 2'b01) begin
                checkOutput("bWren0", 32'(fifoWren), 32'h1);
                checkOutput("bData0", fifoData, s0Word);
                checkOutput("bLast0", 32'(fifoLast), 32'(s0Beat == 1));
                checkOutput("bReady1", 32'(s1Ready), 32'h0);
                s0Beat++;
                if (s0Beat == 2) begin s0Beat = 0; s0Pkt++; end
            end else if (expGrantSeq[c] == 2'b10) begin
                checkOutput("bWren1", 32'(fifoWren), 32'h1);
                checkOutput("bData1", fifoData, s1Word);
                checkOutput("bLast1", 32'(fifoLast), 32'(s1Beat == 1));
                checkOutput("bReady0", 32'(s0Ready), 32'h0);
                s1Beat++;
                if (s1Beat == 2) begin s1Beat = 0; s1Pkt++; end
            end else begin
                checkOutput("bIdleWren", 32'(fifoWren), 32'h0);
            end
            stepClock();
        end
        applyStimulus(0, 32'h0, 4'h0, 0, 0, 32'h0, 4'h0, 0, 0);
        checkOutput("bGrantEnd", 32'(grant), 32'h0);
        checkOutput("bCnt0", 32'(pktCnt0), 32'h2);
        checkOutput("bCnt1", 32'(pktCnt1), 32'h2);

        // Owner lock across a three-cycle TVALID gap
        applyStimulus(1, 32'hC0C00000, 4'hF, 0, 1, 32'hD1D1D1D1, 4'hF, 1, 0);
        checkOutput("cIdleGrant", 32'(grant), 32'h0);
        stepClock();
        applyStimulus(1, 32'hC0C00000, 4'hF, 0, 1, 32'hD1D1D1D1, 4'hF, 1, 0);
        checkOutput("cGrant", 32'(grant), 32'h1);
        checkOutput("cData", fifoData, 32'hC0C00000);
        stepClock();
        for (int g = 0; g < 3; g++) begin
            applyStimulus(0, 32'h0, 4'hF, 0, 1, 32'hD1D1D1D1, 4'hF, 1, 0);
            checkOutput("cGapGrant", 32'(grant), 32'h1);
            checkOutput("cGapReady1", 32'(s1Ready), 32'h0);
            checkOutput("cGapWren", 32'(fifoWren), 32'h0);
            stepClock();
        end
        applyStimulus(1, 32'hC0C00001, 4'hF, 1, 1, 32'hD1D1D1D1, 4'hF, 1, 0);
        checkOutput("cLastWren", 32'(fifoWren), 32'h1);
        checkOutput("cLast", 32'(fifoLast), 32'h1);
        checkOutput("cLastReady1", 32'(s1Ready), 32'h0);
        stepClock();
        applyStimulus(0, 32'h0, 4'h0, 0, 1, 32'hD1D1D1D1, 4'hF, 1, 0);
        checkOutput("cBubbleGrant", 32'(grant), 32'h0);
        checkOutput("cBubbleReady1", 32'(s1Ready), 32'h0);
        checkOutput("cCnt0", 32'(pktCnt0), 32'h3);
        stepClock();
        applyStimulus(0, 32'h0, 4'h0, 0, 1, 32'hD1D1D1D1, 4'hF, 1, 0);
        checkOutput("cSingleGrant", 32'(grant), 32'h2);
        checkOutput("cSingleReady1", 32'(s1Ready), 32'h1);
        checkOutput("cSingleData", fifoData, 32'hD1D1D1D1);
        checkOutput("cSingleLast", 32'(fifoLast), 32'h1);
        stepClock();
        applyStimulus(0, 32'h0, 4'h0, 0, 0, 32'h0, 4'h0, 0, 0);
        checkOutput("cEndGrant", 32'(grant), 32'h0);
        checkOutput("cCnt1", 32'(pktCnt1), 32'h3);

        // FIFO_FULL held for five cycles in the middle of a packet
        applyStimulus(1, 32'hE0000000, 4'hF, 0, 0, 32'h0, 4'h0, 0, 0);
        checkOutput("dIdleGrant", 32'(grant), 32'h0);
        stepClock();
        wrenCount = 0;
        applyStimulus(1, 32'hE0000000, 4'hF, 0, 0, 32'h0, 4'h0, 0, 0);
        checkOutput("dWren0", 32'(fifoWren), 32'h1);
        checkOutput("dData0", fifoData, 32'hE0000000);
        if (fifoWren) wrenCount++;
        stepClock();
        for (int f = 0; f < 5; f++) begin
            applyStimulus(1, 32'hE0000001, 4'hF, 0, 0, 32'h0, 4'h0, 0, 1);
            checkOutput("dFullReady", 32'(s0Ready), 32'h0);
            checkOutput("dFullWren", 32'(fifoWren), 32'h0);
            checkOutput("dFullGrant", 32'(grant), 32'h1);
            if (fifoWren) wrenCount++;
            stepClock();
        end
        for (int b = 1; b < 4; b++) begin
            applyStimulus(1, 32'hE0000000 + 32'(b), 4'hF, (b == 3), 0, 32'h0, 4'h0, 0, 0);
            checkOutput("dWren", 32'(fifoWren), 32'h1);
            checkOutput("dData", fifoData, 32'hE0000000 + 32'(b));
            if (fifoWren) wrenCount++;
            stepClock();
        end
        applyStimulus(0, 32'h0, 4'h0, 0, 0, 32'h0, 4'h0, 0, 0);
        checkOutput("dBeatCount", 32'(wrenCount), 32'h4);
        checkOutput("dCnt0Wrap", 32'(pktCnt0), 32'h0);

        // Strobe masking, then reset in the second beat of an S1 packet
        applyStimulus(0, 32'h0, 4'h0, 0, 1, 32'hAABBCCDD, 4'b0101, 0, 0);
        checkOutput("eIdleData", fifoData, 32'h0);
        stepClock();
        applyStimulus(0, 32'h0, 4'h0, 0, 1, 32'hAABBCCDD, 4'b0101, 0, 0);
        checkOutput("eCnt1Before", 32'(pktCnt1), 32'h3);
        checkOutput("eGrant", 32'(grant), 32'h2);
        checkOutput("eMaskData", fifoData, 32'h00BB00DD);
        checkOutput("eMaskLast", 32'(fifoLast), 32'h0);
        stepClock();
        aresetn = 1'b0;
        applyStimulus(0, 32'h0, 4'h0, 0, 1, 32'h12345678, 4'hF, 1, 0);
        stepClock();
        applyStimulus(0, 32'h0, 4'h0, 0, 1, 32'h12345678, 4'hF, 1, 0);
        checkOutput("eRstCnt1", 32'(pktCnt1), 32'h0);
        checkOutput("eRstGrant", 32'(grant), 32'h0);
        checkOutput("eRstReady1", 32'(s1Ready), 32'h0);
        checkOutput("eRstWren", 32'(fifoWren), 32'h0);
        checkOutput("eRstData", fifoData, 32'h0);
        checkOutput("eRstLast", 32'(fifoLast), 32'h0);
        stepClock();
        aresetn = 1'b1;
        applyStimulus(1, 32'h00000005, 4'hF, 1, 1, 32'h00000006, 4'hF, 1, 0);
        checkOutput("eTieIdle", 32'(grant), 32'h0);
        stepClock();
        applyStimulus(1, 32'h00000005, 4'hF, 1, 1, 32'h00000006, 4'hF, 1, 0);
        checkOutput("eTieGrant", 32'(grant), 32'h1);
        checkOutput("eTieReady0", 32'(s0Ready), 32'h1);
        checkOutput("eTieReady1", 32'(s1Ready), 32'h0);
        checkOutput("eTieData", fifoData, 32'h00000005);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/vmx_stream_arbiter.md
VMX_STREAM_ARBITER -- requirements
Module: vmx_stream_arbiter

Interface
REQ-001 Parameter: C_S_AXIS_TDATA_WIDTH, 32, data width of both slave ports and FIFO_DATA; SHALL be a multiple of 8.
REQ-002 Parameter: C_PKT_CNT_WIDTH, 16, width of each per-port packet counter.
REQ-003 S_AXIS_ACLK  input  1  single clock; all logic on its rising edge.
REQ-004 S_AXIS_ARESETN  input  1  reset, synchronous, active-low.
REQ-005 S0_AXIS_TDATA / S1_AXIS_TDATA  input  C_S_AXIS_TDATA_WIDTH  stream data, requester 0 / 1.
REQ-006 S0_AXIS_TSTRB / S1_AXIS_TSTRB  input  C_S_AXIS_TDATA_WIDTH/8  byte strobes.
REQ-007 S0_AXIS_TLAST / S1_AXIS_TLAST  input  1  end of packet.
REQ-008 S0_AXIS_TVALID / S1_AXIS_TVALID  input  1  beat valid.
REQ-009 S0_AXIS_TREADY / S1_AXIS_TREADY  output  1  beat accepted.
REQ-010 FIFO_DATA  output  C_S_AXIS_TDATA_WIDTH  strobe-masked beat to the shared engine input FIFO.
REQ-011 FIFO_LAST  output  1  TLAST of the written beat.
REQ-012 FIFO_WREN  output  1  FIFO write enable.
REQ-013 FIFO_FULL  input  1  FIFO cannot accept a write this cycle.
REQ-014 GRANT  output  2  one-hot current owner (bit n = requester n); 00 when idle.
REQ-015 PKT_CNT0 / PKT_CNT1  output  C_PKT_CNT_WIDTH  completed packets per requester.

Function
REQ-016 FSM states S_IDLE, S_GRANT0, S_GRANT1; arbitration granularity is one whole packet (TVALID..TLAST).
REQ-017 S_IDLE: if only Sn_AXIS_TVALID is high -> S_GRANTn; if both -> grant the requester not in register last_served; if neither -> stay.
REQ-018 S_GRANTn: stay until a handshake on Sn with TLAST=1, then -> S_IDLE and last_served <= n.
REQ-019 Owner lock: a granted requester keeps the grant across TVALID gaps mid-packet; the other requester SHALL NOT be served until that TLAST.
REQ-020 Sn_AXIS_TREADY = (state == S_GRANTn) && !FIFO_FULL, combinational; the non-owner's TREADY and both TREADYs in S_IDLE are 0.
REQ-021 FIFO_WREN = owner TVALID && owner TREADY; a beat is written in the same cycle as its handshake (zero latency); no write when FIFO_FULL=1.
REQ-022 FIFO_DATA byte i = owner TDATA byte i if TSTRB[i]=1, else 8'h00; FIFO_LAST = owner TLAST; both 0 when no owner.
REQ-023 One S_IDLE bubble cycle separates consecutive packets; the maximum write rate is one beat per cycle within a packet.
REQ-024 PKT_CNTn increments by 1 on each TLAST handshake from requester n; wraps from all-ones to 0 without saturation.
REQ-025 FIFO_FULL asserting mid-packet stalls the owner only; grant and FSM state are unchanged.
REQ-026 A single-beat packet (TVALID with TLAST on the first beat) completes in one grant cycle and returns to S_IDLE.
REQ-027 GRANT is a registered decode of state and equals the one-hot owner in S_GRANTn.

Reset
REQ-028 While S_AXIS_ARESETN=0 at a clock edge: state <= S_IDLE, last_served <= 1 (requester 0 wins the first tie), PKT_CNT0/1 <= 0, GRANT <= 00.
REQ-029 Consequently both TREADY, FIFO_WREN, FIFO_LAST = 0 and FIFO_DATA = 0 during reset.
REQ-030 Reset asserted mid-packet abandons the packet; no partial-packet recovery; beats already written stay in the FIFO.

Structure
REQ-031 Shared package vmx_pkg holds the state encoding constants (S_IDLE, S_GRANT0, S_GRANT1) and the default data-width constant.
REQ-032 One sub-module, vmx_strb_mask, implements the combinational TSTRB byte masking of REQ-022; the FSM, mux and counters stay in the top.

Verification
REQ-033 Only S0 sends a 4-beat packet (TDATA 0x11111111..0x44444444, TSTRB=4'hF), FIFO_FULL=0 -> 4 consecutive FIFO_WREN cycles, FIFO_LAST on the 4th only, PKT_CNT0=1.
REQ-034 S0 and S1 both valid out of reset, 2-beat packets each, repeated twice -> grant order S0,S1,S0,S1; one idle cycle between packets; PKT_CNT0=PKT_CNT1=2.
REQ-035 S0 owns the grant, S1 valid throughout, S0 drops TVALID for 3 cycles mid-packet -> GRANT stays 01, S1_AXIS_TREADY=0 until S0 TLAST.
REQ-036 FIFO_FULL=1 for 5 cycles mid-packet -> owner TREADY=0 and FIFO_WREN=0 for exactly those cycles; no beat lost or duplicated.
REQ-037 TDATA=0xAABBCCDD, TSTRB=4'b0101 -> FIFO_DATA=0x00BB00DD.
REQ-038 Reset pulsed during the 2nd beat of an S1 packet, with C_PKT_CNT_WIDTH=2 after 3 prior S1 packets -> PKT_CNT1 cleared to 0, state S_IDLE, next tie granted to S0.
